// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared ALU setup types and helpers
package hsv_core_pkg;
  typedef enum logic [1:0] {
    ALU_BITWISE_AND  = 2'b00,
    ALU_BITWISE_OR   = 2'b01,
    ALU_BITWISE_XOR  = 2'b10,
    ALU_BITWISE_PASS = 2'b11
  } alu_bitwise_e;
  typedef struct packed {
    alu_bitwise_e bitwise_select;
    logic         negate;
    logic         flip_signs;
    logic         sign_extend;
    logic         is_immediate;
    logic         pc_relative;
    logic         word_op;
  } alu_setup_op_t;
  function automatic logic [64:0] sext_xlen1(input logic [63:0] v, input logic narrow);
    return narrow ? {32'b0, v[31], v[31:0]} : {v[63], v};
  endfunction
endpackage

// File: rtl/hsv_core_alu_setup_comb.sv
// hsv_core_alu_setup_comb: combinational operand, shift-lane and adder-operand compute
module hsv_core_alu_setup_comb
  import hsv_core_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  alu_setup_op_t      op,
  input  logic [XLEN-1:0]    rs1,
  input  logic [XLEN-1:0]    rs2,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    shift_lo,
  output logic [XLEN-1:0]    shift_hi,
  output logic [SHAMT_W-1:0] shift_count,
  output logic [XLEN:0]      adder_a,
  output logic [XLEN:0]      adder_b
);
  logic            wop, bnz, shl;
  logic [XLEN-1:0] a, b, b_raw;
  logic [XLEN:0]   sb, bn;
  always_comb begin
    wop   = (XLEN == 64) && op.word_op;
    b_raw = op.is_immediate ? imm : rs2;
    a     = wop ? XLEN'($signed(rs1[31:0])) : rs1;
    b     = wop ? XLEN'($signed(b_raw[31:0])) : b_raw;
    bnz   = |b;
    shl   = op.negate & bnz;
    sb    = (XLEN+1)'(sext_xlen1(64'(b), XLEN == 32));
    bn    = op.negate ? -sb : sb;
    adder_a = op.pc_relative ? {1'b0, pc} :
              op.flip_signs  ? {~a[XLEN-1], a} : {1'b0, a};
    adder_b = op.flip_signs ? {~bn[XLEN], bn[XLEN-1:0]} : {bnz, bn[XLEN-1:0]};
    shift_lo = op.bitwise_select == ALU_BITWISE_AND ? a & b :
               op.bitwise_select == ALU_BITWISE_OR  ? a | b :
               op.bitwise_select == ALU_BITWISE_XOR ? a ^ b :
               shl ? '0 : a;
    // a negated count turns a left shift into a right shift of the {a, 0} funnel
    shift_count = op.bitwise_select != ALU_BITWISE_PASS ? '0 :
                  bn[SHAMT_W-1:0] & SHAMT_W'(wop ? 31 : XLEN - 1);
    shift_hi = shl ? a : {XLEN{op.sign_extend & a[XLEN-1]}};
  end
endmodule

// File: rtl/hsv_core_alu_setup_stage.sv
// hsv_core_alu_setup_stage: registered ALU operand setup with valid/ready and a 2-entry skid buffer
module hsv_core_alu_setup_stage
  import hsv_core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk_core,
  input  logic               rst_core,
  input  logic               flush_req,
  input  logic               valid_i,
  output logic               ready_o,
  input  alu_setup_op_t      in_op,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               valid_o,
  input  logic               ready_i,
  output alu_setup_op_t      out_op,
  output logic [TAG_W-1:0]   out_tag,
  output logic [XLEN-1:0]    out_shift_lo,
  output logic [XLEN-1:0]    out_shift_hi,
  output logic [SHAMT_W-1:0] out_shift_count,
  output logic [XLEN:0]      out_adder_a,
  output logic [XLEN:0]      out_adder_b
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("hsv_core_alu_setup_stage: XLEN must be 32 or 64");
  end
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;
  typedef struct packed {
    alu_setup_op_t      op;
    logic [TAG_W-1:0]   tag;
    logic [XLEN-1:0]    lo;
    logic [XLEN-1:0]    hi;
    logic [SHAMT_W-1:0] cnt;
    logic [XLEN:0]      aa;
    logic [XLEN:0]      ab;
  } entry_t;
  state_e             state_q, state_d;
  entry_t             cur, main_q, skid_q;
  logic               rdy_q, acc, xfer, ld_main, ld_skid;
  logic [XLEN-1:0]    c_lo, c_hi;
  logic [SHAMT_W-1:0] c_cnt;
  logic [XLEN:0]      c_aa, c_ab;
  hsv_core_alu_setup_comb #(.XLEN(XLEN)) u_comb (
    .op(in_op), .rs1(in_rs1), .rs2(in_rs2), .imm(in_imm), .pc(in_pc),
    .shift_lo(c_lo), .shift_hi(c_hi), .shift_count(c_cnt),
    .adder_a(c_aa), .adder_b(c_ab)
  );
  assign cur = '{op: in_op, tag: in_tag, lo: c_lo, hi: c_hi, cnt: c_cnt, aa: c_aa, ab: c_ab};
  assign ready_o = rdy_q;
  assign valid_o = state_q != ST_EMPTY;
  assign {out_op, out_tag, out_shift_lo, out_shift_hi, out_shift_count, out_adder_a, out_adder_b} = main_q;
  always_comb begin
    acc     = valid_i & ready_o;
    xfer    = valid_o & ready_i;
    state_d = flush_req           ? ST_EMPTY :
              state_q == ST_EMPTY ? (acc ? ST_FULL : ST_EMPTY) :
              state_q == ST_FULL  ? (acc ? (xfer ? ST_FULL : ST_SKID) : (xfer ? ST_EMPTY : ST_FULL)) :
              (xfer ? ST_FULL : ST_SKID);
    ld_main = ~flush_req & ((state_q == ST_EMPTY & acc) | (state_q == ST_FULL & acc & xfer) |
                            (state_q == ST_SKID & xfer));
    ld_skid = ~flush_req & state_q == ST_FULL & acc & ~xfer;
  end
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= state_d != ST_SKID;
      if (ld_main) main_q <= state_q == ST_SKID ? skid_q : cur;
      if (ld_skid) skid_q <= cur;
    end
  end
endmodule
